// File: rtl/uart_xcvr_param_if.sv
// Host/line signal bundle for uart_xcvr_param.
// slave = transceiver side, master = host/line side.
interface uart_xcvr_param_if #(
   parameter int unsigned DATA_W = 8
) ();
   logic [DATA_W-1:0] TX_DATA;
   logic              TX_VALID;
   logic              TX_READY;
   logic              TX_SERIAL;
   logic              RX_SERIAL;
   logic [DATA_W-1:0] RX_DATA;
   logic              RX_VALID;
   logic              RX_PARITY_ERR;
   logic              RX_FRAME_ERR;

   modport slave (
      input  TX_DATA, TX_VALID, RX_SERIAL,
      output TX_READY, TX_SERIAL, RX_DATA, RX_VALID, RX_PARITY_ERR, RX_FRAME_ERR
   );

   modport master (
      output TX_DATA, TX_VALID, RX_SERIAL,
      input  TX_READY, TX_SERIAL, RX_DATA, RX_VALID, RX_PARITY_ERR, RX_FRAME_ERR
   );
endinterface

// File: rtl/uart_xcvr_param.sv
// Parametrised full-duplex UART: ready/valid TX, oversampled mid-bit RX with
// synchroniser, optional parity, 1/2 stop bits, parity and framing error flags.
module uart_xcvr_param #(
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned PARITY_EN    = 1,
   parameter int unsigned PARITY_ODD   = 0,
   parameter int unsigned STOP_BITS    = 1,
   parameter int unsigned SYNC_STAGES  = 2
) (
   input logic              UART_CLK,
   input logic              UART_RST_N,
   uart_xcvr_param_if.slave bus
);

   localparam int unsigned CntMax = (CLKS_PER_BIT > DATA_W + 3) ? CLKS_PER_BIT : DATA_W + 3;
   localparam int unsigned CntW   = $clog2(CntMax);
   localparam int unsigned Half   = CLKS_PER_BIT / 2;

   localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
   localparam logic [CntW-1:0] HalfLast = CntW'((Half == 0) ? 0 : Half - 1);
   localparam logic [CntW-1:0] DataLast = CntW'(DATA_W - 1);
   localparam logic [CntW-1:0] StopLast = CntW'(STOP_BITS - 1);
   localparam logic            OddBit   = (PARITY_ODD != 0);
   localparam logic            ParEn    = (PARITY_EN != 0);

   // ---------------------------------------------------------------- transmitter
   typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;

   tx_state_e         tx_state_q, tx_state_d;
   logic [CntW-1:0]   tx_cyc_q, tx_cyc_d;
   logic [CntW-1:0]   tx_bit_q, tx_bit_d;
   logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
   logic              tx_par_q, tx_par_d;
   logic              tx_ready, tx_serial, tx_cyc_end;

   always_ff @(posedge UART_CLK or negedge UART_RST_N) begin
      if (!UART_RST_N) begin
         tx_state_q <= TxIdle;
         tx_cyc_q   <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
         tx_par_q   <= 1'b0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cyc_q   <= tx_cyc_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         tx_par_q   <= tx_par_d;
      end
   end

   always_comb begin
      tx_state_d = tx_state_q;
      tx_cyc_d   = tx_cyc_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      tx_par_d   = tx_par_q;
      tx_ready   = 1'b0;
      tx_serial  = 1'b1;
      tx_cyc_end = (tx_cyc_q == BitLast);
      if (tx_state_q != TxIdle) begin
         tx_cyc_d = tx_cyc_end ? '0 : tx_cyc_q + 1'b1;
      end
      unique case (tx_state_q)
         TxIdle: begin
            tx_ready = 1'b1;
            if (bus.TX_VALID) begin
               tx_shift_d = bus.TX_DATA;
               tx_par_d   = (^bus.TX_DATA) ^ OddBit;
               tx_cyc_d   = '0;
               tx_bit_d   = '0;
               tx_state_d = TxStart;
            end
         end
         TxStart: begin
            tx_serial = 1'b0;
            if (tx_cyc_end) tx_state_d = TxData;
         end
         TxData: begin
            tx_serial = tx_shift_q[0];
            if (tx_cyc_end) begin
               tx_shift_d = tx_shift_q >> 1;
               tx_bit_d   = tx_bit_q + 1'b1;
               if (tx_bit_q == DataLast) begin
                  tx_bit_d   = '0;
                  tx_state_d = ParEn ? TxParity : TxStop;
               end
            end
         end
         TxParity: begin
            tx_serial = tx_par_q;
            if (tx_cyc_end) tx_state_d = TxStop;
         end
         TxStop: begin
            if (tx_cyc_end) begin
               if (tx_bit_q == StopLast) tx_state_d = TxIdle;
               else                      tx_bit_d   = tx_bit_q + 1'b1;
            end
         end
         default: tx_state_d = TxIdle;
      endcase
   end

   assign bus.TX_READY  = tx_ready;
   assign bus.TX_SERIAL = tx_serial;

   // ---------------------------------------------------------------- receiver
   logic rx_s;

   if (SYNC_STAGES == 0) begin : g_nosync
      assign rx_s = bus.RX_SERIAL;
   end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      always_ff @(posedge UART_CLK or negedge UART_RST_N) begin
         if (!UART_RST_N) begin
            sync_q <= '1;
         end else begin
            sync_q[0] <= bus.RX_SERIAL;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         end
      end
      assign rx_s = sync_q[SYNC_STAGES-1];
   end

   typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop, RxBreak} rx_state_e;

   rx_state_e         rx_state_q, rx_state_d;
   logic [CntW-1:0]   rx_cyc_q, rx_cyc_d;
   logic [CntW-1:0]   rx_bit_q, rx_bit_d;
   logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
   logic              rx_perr_q, rx_perr_d;
   logic              rx_serr_q, rx_serr_d;
   logic [DATA_W-1:0] rx_data_q, rx_data_d;
   logic              rx_valid_q, rx_valid_d;
   logic              rx_pflag_q, rx_pflag_d;
   logic              rx_fflag_q, rx_fflag_d;
   logic              rx_cyc_end, rx_ferr;

   always_ff @(posedge UART_CLK or negedge UART_RST_N) begin
      if (!UART_RST_N) begin
         rx_state_q <= RxIdle;
         rx_cyc_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         rx_perr_q  <= 1'b0;
         rx_serr_q  <= 1'b0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         rx_pflag_q <= 1'b0;
         rx_fflag_q <= 1'b0;
      end else begin
         rx_state_q <= rx_state_d;
         rx_cyc_q   <= rx_cyc_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
         rx_perr_q  <= rx_perr_d;
         rx_serr_q  <= rx_serr_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         rx_pflag_q <= rx_pflag_d;
         rx_fflag_q <= rx_fflag_d;
      end
   end

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cyc_d   = rx_cyc_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_perr_d  = rx_perr_q;
      rx_serr_d  = rx_serr_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      rx_pflag_d = rx_pflag_q;
      rx_fflag_d = rx_fflag_q;
      rx_cyc_end = (rx_cyc_q == BitLast);
      rx_ferr    = rx_serr_q | ~rx_s;
      if (rx_state_q inside {RxData, RxParity, RxStop}) begin
         rx_cyc_d = rx_cyc_end ? '0 : rx_cyc_q + 1'b1;
      end
      unique case (rx_state_q)
         RxIdle: begin
            if (!rx_s) begin
               rx_cyc_d   = '0;
               rx_bit_d   = '0;
               rx_perr_d  = 1'b0;
               rx_serr_d  = 1'b0;
               // With one clock per bit the detecting sample already is mid-bit.
               rx_state_d = (Half == 0) ? RxData : RxStart;
            end
         end
         RxStart: begin
            if (rx_cyc_q == HalfLast) begin
               rx_cyc_d   = '0;
               rx_state_d = rx_s ? RxIdle : RxData;
            end else begin
               rx_cyc_d = rx_cyc_q + 1'b1;
            end
         end
         RxData: begin
            if (rx_cyc_end) begin
               rx_shift_d = {rx_s, rx_shift_q[DATA_W-1:1]};
               rx_bit_d   = rx_bit_q + 1'b1;
               if (rx_bit_q == DataLast) begin
                  rx_bit_d   = '0;
                  rx_state_d = ParEn ? RxParity : RxStop;
               end
            end
         end
         RxParity: begin
            if (rx_cyc_end) begin
               rx_perr_d  = rx_s ^ (^rx_shift_q) ^ OddBit;
               rx_state_d = RxStop;
            end
         end
         RxStop: begin
            if (rx_cyc_end) begin
               if (rx_bit_q == StopLast) begin
                  rx_valid_d = 1'b1;
                  rx_data_d  = rx_shift_q;
                  rx_pflag_d = rx_perr_q;
                  rx_fflag_d = rx_ferr;
                  rx_state_d = rx_ferr ? RxBreak : RxIdle;
               end else begin
                  rx_serr_d = rx_ferr;
                  rx_bit_d  = rx_bit_q + 1'b1;
               end
            end
         end
         // A line stuck low must go high before another start bit is accepted.
         RxBreak: begin
            if (rx_s) rx_state_d = RxIdle;
         end
         default: rx_state_d = RxIdle;
      endcase
   end

   assign bus.RX_DATA       = rx_data_q;
   assign bus.RX_VALID      = rx_valid_q;
   assign bus.RX_PARITY_ERR = rx_pflag_q;
   assign bus.RX_FRAME_ERR  = rx_fflag_q;

endmodule

// File: doc/uart_xcvr_param.md
Name: uart_xcvr_param

Overview:
Parametrised full-duplex UART transceiver; successor to the fixed 8-bit, one-bit-per-clock UART_1/UART_2 pair. Adds configurable data width, oversampling (clocks per bit), optional even/odd parity, 1 or 2 stop bits, a ready/valid TX handshake, mid-bit RX sampling with an input synchroniser, and parity/framing error flags. Sits between the host-side byte interface and the serial line. Two instances cross-wired form the UART loopback testbench.

Parameters:
DATA_W, 8, data bits per frame (5..16)
CLKS_PER_BIT, 16, clock cycles per serial bit (>=1)
PARITY_EN, 1, 1 = parity bit after data, 0 = none
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored if PARITY_EN=0)
STOP_BITS, 1, number of stop bits (1 or 2)
SYNC_STAGES, 2, RX input synchroniser flops (0 = bypass)

Ports:
UART_CLK  in  1  single clock for TX and RX
UART_RST_N  in  1  asynchronous, active-low reset
TX_DATA  in  DATA_W  word to transmit
TX_VALID  in  1  TX_DATA valid
TX_READY  out  1  transmitter can accept a word
TX_SERIAL  out  1  serial line out, idles high
RX_SERIAL  in  1  serial line in, idles high
RX_DATA  out  DATA_W  last received word, LSB = first data bit
RX_VALID  out  1  one-cycle pulse, new word on RX_DATA
RX_PARITY_ERR  out  1  parity mismatch, valid with RX_VALID
RX_FRAME_ERR  out  1  stop bit sampled 0, valid with RX_VALID

Behaviour:
- Reset (async, RST_N=0): TX_SERIAL=1, TX_READY=1, RX_DATA=0, RX_VALID=0, both error flags 0, both FSMs to IDLE, counters 0, synchroniser flops to 1. Reset mid-frame aborts the frame; nothing partial is delivered.
- Frame on line: start(0), DATA_W data bits LSB first, parity bit if PARITY_EN, STOP_BITS x 1. Each bit is held exactly CLKS_PER_BIT cycles.
- Parity bit = XOR(data) ^ PARITY_ODD.
- TX FSM: IDLE -> START -> DATA -> PARITY (skipped if !PARITY_EN) -> STOP -> IDLE.
  - TX_READY=1 only in IDLE. Accept when TX_VALID&&TX_READY; TX_DATA is latched that edge. TX_SERIAL=0 from the next cycle.
  - A bit counter and a cycle counter advance state. The last stop cycle is followed by one IDLE cycle (TX_READY=1) before a new frame can start.
  - TX_DATA changes after acceptance have no effect.
- RX FSM: IDLE -> START -> DATA -> PARITY (opt.) -> STOP -> IDLE, with a BREAK wait state. Operates on the synchronised RX input, so latency is SYNC_STAGES cycles.
  - IDLE: synchronised line 0 -> START.
  - START: wait CLKS_PER_BIT/2 cycles (integer), resample. If 1, it is a glitch: return to IDLE with no output. If 0, continue.
  - Each later bit is sampled every CLKS_PER_BIT cycles (mid-bit). For CLKS_PER_BIT=1, samples fall on consecutive cycles.
  - Data shifts in LSB first. Parity is compared on the sample; every stop bit is checked.
  - The cycle after the last stop sample: RX_VALID=1 for one cycle, RX_DATA updated, error flags updated. RX_DATA and the flags hold until the next RX_VALID.
  - Framing error: RX_FRAME_ERR=1 and the word is still delivered. The FSM then goes to BREAK and re-arms only after sampling line=1. A held-low line never produces repeated frames.
- TX and RX are fully independent; simultaneous TX accept and RX_VALID are legal.
- Counters are sized by $clog2 of max(CLKS_PER_BIT, DATA_W+3); no wrap within a frame.

Test Plan:
- Defaults, TX 0xA5, TX_SERIAL looped to RX_SERIAL -> line 0,1,0,1,0,0,1,0,1,0(par),1, each 16 cycles (176 total). RX_VALID pulse, RX_DATA=0xA5, both errors 0. TX_READY low 176 cycles, then high.
- Defaults, RX driven with 0x3C data and parity bit 1 -> RX_VALID, RX_DATA=0x3C, RX_PARITY_ERR=1, RX_FRAME_ERR=0.
- Defaults, valid 0x55 frame with stop bit 0, line then held 0 for 500 cycles -> exactly one RX_VALID, RX_FRAME_ERR=1. No further RX_VALID until line returns high and a new frame arrives.
- Defaults, RX_SERIAL low for 4 cycles then high -> no RX_VALID; a following 0x81 frame is received correctly.
- DATA_W=7, CLKS_PER_BIT=1, PARITY_ODD=1, STOP_BITS=2, SYNC_STAGES=0, TX 0x7F looped -> 11-cycle frame 0,1x7,0(par),1,1. RX_DATA=0x7F with no errors.
- Defaults, UART_RST_N pulsed low at data bit 3 of a TX frame -> TX_SERIAL=1 and TX_READY=1 immediately (async), no RX_VALID. The next accepted word transmits correctly.
